rf_read_arbiter: RTL
====================

# rf_read_arbiter

Shares the register file's single combinational read-port pair (rs1/rs2 lookup of value, busy flag and RoB dependency tag) between two requesters: requester 0 is the instruction decoder, requester 1 is the load/store address-resolution unit. It grants round-robin, captures each lookup into a per-requester response slot, and keeps held responses coherent by snooping the RoB commit bus until the requester consumes them. It sits between the requesters and the register file, next to the RoB.

## Interface
- ROB_W, 4, width of a RoB index / dependency tag
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global enable; low freezes all state
- clear_in  input  1  misprediction flush (synchronous)
- reqN_valid  input  1  requester N (N=0,1) lookup request
- reqN_rs1, reqN_rs2  input  5  register ids to look up
- reqN_ready  output  1  request accepted this cycle
- rspN_valid  output  1  response slot N holds a result
- rspN_ready  input  1  requester N consumes the response
- rspN_val1, rspN_val2  output  32  operand values
- rspN_busy1, rspN_busy2  output  1  operand still pending
- rspN_tag1, rspN_tag2  output  ROB_W  RoB index producing the operand; 0 when not busy
- rf_rs1, rf_rs2  output  5  register-file read addresses
- rf_val1, rf_val2  input  32  register-file data
- rf_busy1, rf_busy2  input  1  register-file dependency flags
- rf_tag1, rf_tag2  input  ROB_W  register-file dependency tags
- commit_valid  input  1  RoB commit broadcast
- commit_regid  input  5  committed destination register
- commit_value  input  32  committed value
- commit_robidx  input  ROB_W  committing RoB index

## Operation
- Each requester has a response slot with two states, EMPTY and HELD. rspN_valid = (slot N == HELD).
- Eligibility: requester N is eligible when reqN_valid=1 and slot N is either EMPTY or being drained this cycle (HELD with rspN_ready=1).
- Arbitration: `prio` is a 1-bit register. If both requesters are eligible, grant goes to `prio`, and `prio` is then set to the other requester. If only one is eligible, it is granted and `prio` is set to the other requester. With no grant, `prio` holds.
- reqN_ready = grantN, computed combinationally. reqN_ready is 0 whenever clear_in=1 or rdy_in=0.
- rf_rs1/rf_rs2 carry the granted requester's ids. With no grant, they carry requester 0's ids.
- Capture at the posedge of a grant: the slot loads rf_* and becomes HELD.
  - If a register id is 0: value is 0, busy is 0, tag is 0.
  - Same-edge commit forward: if rf_busy is set, commit_valid=1 and commit_robidx equals rf_tag, capture commit_value with busy=0 and tag=0.
- Snoop while HELD (slot not being consumed): for each operand, if busy=1, commit_valid=1 and commit_robidx equals the tag, load commit_value and clear busy and tag.
- Consume: rspN_ready with HELD and no new grant returns the slot to EMPTY. Consume together with a new grant reloads the slot; it stays HELD.
- clear_in=1 (rdy_in=1): both slots go to EMPTY, no grant, `prio` unchanged. clear_in has priority over consume, grant and snoop.
- rdy_in=0: no state changes at all, including snoop. Outputs hold.

## Timing
- Asynchronous reset (rst_n_in=0):
  - Slots EMPTY, `prio`=0.
  - All rsp data, busy and tag registers are 0.
  - rspN_valid=0. reqN_ready=0 while reset is asserted.
- Latency: a request accepted on edge k shows rspN_valid=1 with data after edge k, i.e. during cycle k+1.
- Throughput: one lookup per cycle in total. A requester that consumes every cycle can be granted every cycle when uncontested.
- Under contention the two requesters alternate, with at most one cycle of wait each.
- Response outputs are registered. reqN_ready and rf_rs1/rf_rs2 are combinational from the request, slot and `prio` state.
- Reset asserted mid-transaction drops in-flight and held responses immediately. There are no glitch requirements on combinational outputs.

## Test plan
- Reset, then req0 with rs1=5, rs2=0, RF returning val1=0x1234 not busy: reqN_ready=1 that cycle; next cycle rsp0_valid=1, val1=0x1234, val2=0, busy1=busy2=0.
- Both requesters valid for 4 cycles with consumers always ready: grants go 0,1,0,1 and each rsp asserts exactly one cycle after its grant.
- req1 looks up rs1=7 with RF busy and tag=3; rsp1_ready held 0; two cycles later commit_valid with robidx=3 and value=0xDEAD: rsp1_val1=0xDEAD, busy1=0, tag1=0 on the next cycle. A commit with robidx=2 leaves the response unchanged.
- Same-edge forward: grant with rf_busy1=1 and tag=6 while commit_robidx=6 and value=0x55: the response shows val1=0x55, busy1=0.
- Slot 0 HELD with rsp0_ready=0 and req0_valid=1: req0_ready stays 0 until rsp0_ready=1. Drain plus new grant in that same cycle keeps rsp0_valid=1 with the new data.
- Both slots HELD, then clear_in=1 together with req1_valid: the next cycle has both rsp valids at 0, no grant, and `prio` unchanged. rdy_in=0 for 3 cycles with a matching commit leaves all outputs frozen.

Source files
------------

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: round-robin sharing of the register-file read port between decoder and LSU,
// with per-requester response slots kept coherent by snooping RoB commits.
module rf_read_arbiter #(
    parameter int ROB_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             req0_valid,
    input  logic [4:0]       req0_rs1,
    input  logic [4:0]       req0_rs2,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_rs1,
    input  logic [4:0]       req1_rs2,
    output logic             req1_ready,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_val1,
    output logic [31:0]      rsp0_val2,
    output logic             rsp0_busy1,
    output logic             rsp0_busy2,
    output logic [ROB_W-1:0] rsp0_tag1,
    output logic [ROB_W-1:0] rsp0_tag2,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_val1,
    output logic [31:0]      rsp1_val2,
    output logic             rsp1_busy1,
    output logic             rsp1_busy2,
    output logic [ROB_W-1:0] rsp1_tag1,
    output logic [ROB_W-1:0] rsp1_tag2,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    input  logic [31:0]      rf_val1,
    input  logic [31:0]      rf_val2,
    input  logic             rf_busy1,
    input  logic             rf_busy2,
    input  logic [ROB_W-1:0] rf_tag1,
    input  logic [ROB_W-1:0] rf_tag2,
    input  logic             commit_valid,
    input  logic [4:0]       commit_regid,
    input  logic [31:0]      commit_value,
    input  logic [ROB_W-1:0] commit_robidx
);
    typedef enum logic {EMPTY, HELD} slot_t;
    slot_t            slot_q [2], slot_d [2];
    logic             prio_q, prio_d;
    logic [31:0]      val_q  [2][2], val_d  [2][2];
    logic             busy_q [2][2], busy_d [2][2];
    logic [ROB_W-1:0] tag_q  [2][2], tag_d  [2][2];
    logic [1:0]       req_valid, rsp_ready, elig, gnt;
    logic [4:0]       rs [2];
    logic [31:0]      rf_val [2], cap_val [2];
    logic             rf_busy [2], cap_busy [2];
    logic [ROB_W-1:0] rf_tag [2], cap_tag [2];
    logic             en;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign rf_val    = '{rf_val1, rf_val2};
    assign rf_busy   = '{rf_busy1, rf_busy2};
    assign rf_tag    = '{rf_tag1, rf_tag2};
    assign rs        = '{rf_rs1, rf_rs2};

    always_comb begin
        en      = rdy_in & ~clear_in & rst_n_in;
        elig[0] = req0_valid & ((slot_q[0] == EMPTY) | rsp0_ready);
        elig[1] = req1_valid & ((slot_q[1] == EMPTY) | rsp1_ready);
        gnt[0]  = en & elig[0] & (~elig[1] | ~prio_q);
        gnt[1]  = en & elig[1] & (~elig[0] | prio_q);
        prio_d  = gnt[0] ? 1'b1 : (gnt[1] ? 1'b0 : prio_q);
        rf_rs1  = gnt[1] ? req1_rs1 : req0_rs1;
        rf_rs2  = gnt[1] ? req1_rs2 : req0_rs2;
        // x0 reads as a constant zero; a same-edge commit overrides a stale busy entry
        for (int k = 0; k < 2; k++) begin
            cap_val[k]  = (rs[k] == 5'd0) ? 32'd0 :
                          (rf_busy[k] & commit_valid & (commit_robidx == rf_tag[k])) ? commit_value : rf_val[k];
            cap_busy[k] = (rs[k] != 5'd0) & rf_busy[k] & ~(commit_valid & (commit_robidx == rf_tag[k]));
            cap_tag[k]  = cap_busy[k] ? rf_tag[k] : '0;
        end
        for (int n = 0; n < 2; n++) begin
            slot_d[n] = slot_q[n];
            for (int k = 0; k < 2; k++) begin
                val_d[n][k]  = val_q[n][k];
                busy_d[n][k] = busy_q[n][k];
                tag_d[n][k]  = tag_q[n][k];
            end
            if (clear_in) begin
                slot_d[n] = EMPTY;
            end else if (gnt[n]) begin
                slot_d[n] = HELD;
                for (int k = 0; k < 2; k++) begin
                    val_d[n][k]  = cap_val[k];
                    busy_d[n][k] = cap_busy[k];
                    tag_d[n][k]  = cap_tag[k];
                end
            end else if (slot_q[n] == HELD && rsp_ready[n]) begin
                slot_d[n] = EMPTY;
            end else if (slot_q[n] == HELD) begin
                for (int k = 0; k < 2; k++) begin
                    if (busy_q[n][k] && commit_valid && commit_robidx == tag_q[n][k]) begin
                        val_d[n][k]  = commit_value;
                        busy_d[n][k] = 1'b0;
                        tag_d[n][k]  = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            slot_q <= '{default: EMPTY};
            prio_q <= 1'b0;
            val_q  <= '{default: '0};
            busy_q <= '{default: 1'b0};
            tag_q  <= '{default: '0};
        end else if (rdy_in) begin
            slot_q <= slot_d;
            prio_q <= prio_d;
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign rsp0_valid = slot_q[0] == HELD;
    assign rsp1_valid = slot_q[1] == HELD;
    assign rsp0_val1  = val_q[0][0];
    assign rsp0_val2  = val_q[0][1];
    assign rsp0_busy1 = busy_q[0][0];
    assign rsp0_busy2 = busy_q[0][1];
    assign rsp0_tag1  = tag_q[0][0];
    assign rsp0_tag2  = tag_q[0][1];
    assign rsp1_val1  = val_q[1][0];
    assign rsp1_val2  = val_q[1][1];
    assign rsp1_busy1 = busy_q[1][0];
    assign rsp1_busy2 = busy_q[1][1];
    assign rsp1_tag1  = tag_q[1][0];
    assign rsp1_tag2  = tag_q[1][1];
endmodule
